inst_prefetch_buffer: RTL

- Instruction fetch front-end that sits directly upstream of the RV32E core's decode stage.
- Issues sequential word reads to a synchronous single-port instruction SRAM with fixed 1-cycle read latency.
- Buffers returned words with their PCs in a small FIFO and presents them to the core with a valid/ack handshake.
- Handles core redirects (branch/jump) by flushing buffered and in-flight fetches and restarting at the new PC.

---
 rtl/inst_prefetch_buffer_pkg.sv | 17 +
 rtl/inst_prefetch_buffer_fetch_fifo.sv | 58 +++++
 rtl/inst_prefetch_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
//   NOP           : canonical RV32 no-op (addi x0, x0, 0), shown when nothing is buffered
//   PC_STEP       : byte distance between sequential instruction words
//   ENTRY_PC_W    : PC width carried inside a buffered entry
//   fetch_entry_t : one buffered fetch, {pc, instr}
package inst_prefetch_buffer_pkg;

  localparam int unsigned ENTRY_PC_W = 32;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int unsigned PC_STEP    = 4;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   count      : number of valid entries, 0..DEPTH
//   head       : entry at the head (meaningless when count is 0)
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_prefetch_buffer_fetch_fifo
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Push at full is legal when paired with a pop: the write lands in the slot
  // being vacated, whose old contents are still presented on head this cycle.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction fetch front-end for the RV32E core.
// Issues sequential word reads to a 1-cycle-latency instruction SRAM, buffers
// returned words with their PCs, and hands them to decode with valid/ack.
// A redirect flushes buffered and in-flight fetches and restarts at the target.
//   clk, rst_n     : clock, synchronous active-low reset
//   boot_addr      : first fetch PC after reset, sampled while rst_n is low
//   imem_cen       : SRAM chip enable, active low (0 = read this cycle)
//   imem_addr      : SRAM byte address, word aligned
//   imem_rdata     : SRAM read data, valid the cycle after a read
//   instr_valid    : head instruction available
//   instr_data     : head instruction (NOP when empty)
//   instr_pc       : head PC (0 when empty)
//   instr_ack      : core consumes the head this cycle
//   redirect_valid : restart fetch at redirect_pc
//   redirect_pc    : restart target, low two bits ignored
module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] boot_addr,
  output logic            imem_cen,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr_data,
  output logic [PC_W-1:0] instr_pc,
  input  logic            instr_ack,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [PC_W-1:0]  fetch_pc_q, inflight_pc_q, next_addr;
  logic             inflight_q;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  fetch_entry_t     head, push_entry;
  logic             redirect, fifo_valid, pop, push, issue;

  assign redirect   = rst_n & redirect_valid;
  assign fifo_valid = rst_n & (count != '0);
  // A redirect discards the head, so an ack in the same cycle is not a pop.
  assign pop        = instr_ack & fifo_valid & ~redirect;

  // Reserve a slot for every outstanding read so a response always fits.
  assign occupancy = {1'b0, count} + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue     = rst_n & (redirect | (occupancy < OCC_W'(DEPTH)));

  assign next_addr = redirect ? {redirect_pc[PC_W-1:2], 2'b00} : fetch_pc_q;
  assign imem_cen  = ~issue;
  assign imem_addr = rst_n ? next_addr : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= {boot_addr[PC_W-1:2], 2'b00};
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        fetch_pc_q    <= next_addr + PC_W'(PC_STEP);
        inflight_pc_q <= next_addr;
      end
    end
  end

  // A response that lands during a redirect belongs to the old stream.
  assign push = rst_n & inflight_q & ~redirect;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = ENTRY_PC_W'(inflight_pc_q);
    push_entry.instr = imem_rdata;
  end

  inst_prefetch_buffer_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  assign instr_valid = fifo_valid;
  assign instr_data  = fifo_valid ? head.instr : NOP;
  assign instr_pc    = fifo_valid ? PC_W'(head.pc) : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{boot_addr[1:0], redirect_pc[1:0]};

endmodule
